temp_rom_arbiter: RTL and testbench
===================================

# temp_rom_arbiter

Sequencer and two-port arbiter in front of the synchronous temperature-conversion ROM (9-bit address, 8-bit data, one-cycle registered read). It accepts conversion requests from two requesters, for example the switch/display path and the serial path. It grants one requester at a time in round-robin order and forms the ROM address from {unit, value}. It waits out the ROM latency and returns the looked-up byte to the granted requester over a valid/ready response handshake. The block sits between the requesters and a single ROM instance; the ROM itself is not instantiated here.

## Interface
- Clock and reset: one clock `clk`; reset is asynchronous, active-low `reset_n`.
- `AW`, default 9: ROM address width. Bit `AW-1` is the unit select; the low 8 bits are the value.
- `DW`, default 8: ROM data and value width.
- `CW`, default 16: width of the completed-conversion counter.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  2: per-requester request valid. Index 0 is requester 0.
- `req_unit`  in  2: per-requester direction. 0 means C→F; 1 means F→C.
- `req_value`  in  2×DW: per-requester input temperature (packed; requester 1 in the upper byte).
- `req_ready`  out  2: per-requester accept strobe (combinational).
- `resp_valid`  out  2: per-requester response valid.
- `resp_data`  out  DW: converted value; shared by both requesters and meaningful only with a `resp_valid` bit.
- `resp_ready`  in  2: per-requester response accept.
- `rom_addr`  out  AW: registered address to the ROM.
- `rom_data`  in  DW: ROM read data, valid one cycle after the address is sampled.
- `busy`  out  1: high whenever the state is not IDLE.
- `conv_count`  out  CW: count of completed responses, saturating at all-ones.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any `req_valid` bit is set, the arbiter grants one requester. `req_ready[g]` is 1 in that same cycle. The block latches `rom_addr <= {req_unit[g], req_value[g]}` and the grant index, then moves to ISSUE.
- ISSUE
  - `rom_addr` is stable and the ROM samples it at the end of this cycle. Next state is WAIT.
- WAIT
  - `rom_data` is valid in this cycle. The block captures it into the `resp_data` register. Next state is RESP.
- RESP
  - `resp_valid[g]` is 1; the other bit is 0. `resp_data` and `rom_addr` are held.
  - On `resp_ready[g]`, `conv_count` increments (saturating), the round-robin pointer moves to the requester other than g, and the state returns to IDLE.
  - `resp_ready` of the non-granted requester is ignored.
- Arbitration
  - A single requester is granted directly.
  - When both requesters are valid in IDLE, the one selected by the pointer wins. The pointer resets to 0.
  - Requesters must hold `req_valid`, `req_unit` and `req_value` stable until they see `req_ready`. Dropping `req_valid` before acceptance simply withdraws the request.
- Only one request is in flight at a time. No request is accepted outside IDLE, so `req_ready` is 0 in ISSUE, WAIT and RESP.
- No arithmetic is done on the data path. The address is a pure concatenation and the data passes through unchanged. `conv_count` is the only arithmetic and it saturates at 2^CW−1.

## Timing
- Reset values:
  - state IDLE
  - `rom_addr` 0
  - `resp_data` 0
  - `resp_valid` 00
  - `req_ready` 00
  - `busy` 0
  - `conv_count` 0
  - RR pointer 0
- Accept in cycle T; ISSUE in T+1; WAIT in T+2; `resp_valid` rises in T+3.
- With `resp_ready` already high, the response handshake completes in T+3 and the state is IDLE in T+4. The earliest next accept is T+4, so the minimum period is 4 cycles per conversion.
- If `resp_ready` is low, RESP holds for any number of cycles. Outputs stay stable and nothing else is accepted.
- Simultaneous requests in IDLE: exactly one `req_ready` bit is ever high.
- Reset asserted mid-operation (any state) returns all outputs to their reset values immediately. The in-flight request is discarded and no response is produced. The requester must re-request.

## Structure
- The shared package `temp_rom_pkg` holds:
  - state enum `state_t` {IDLE, ISSUE, WAIT, RESP}
  - unit constants `UNIT_C2F = 1'b0` and `UNIT_F2C = 1'b1`
  - localparams `ROM_AW = 9` and `ROM_DW = 8`
- One sub-module: `rr_arb2`
  - Inputs: `req[1:0]` and the pointer.
  - Outputs: a one-hot `gnt[1:0]`, combinational.
  - The pointer register stays in the parent so it updates only on response completion.

## Test plan
The bench ROM model has a one-cycle registered read returning `data = addr[7:0] ^ {8{addr[8]}}`.
1. Single C→F request: requester 0, unit 0, value 100, `resp_ready` tied high. Required: `req_ready[0]` high in T, `rom_addr` = 100 from T+1, `resp_valid[0]` and `resp_data` = 100 in T+3, `conv_count` = 1.
2. Single F→C request: requester 1, unit 1, value 0x0F. Required: `rom_addr` = 0x10F, `resp_data` = 0xF0 on `resp_valid[1]`, and `resp_valid[0]` stays 0 throughout.
3. Both requesters held valid continuously: grants alternate 0, 1, 0, 1 and each response comes from the matching requester's value. Four completions occur in 16 cycles.
4. Response backpressure: hold `resp_ready` low for 5 cycles in RESP. Required: `resp_valid`, `resp_data` and `rom_addr` stay stable, `req_ready` = 00 despite a new `req_valid[1]`, and `conv_count` is unchanged until release.
5. Reset mid-operation: pulse `reset_n` low during WAIT. Required: all outputs reset asynchronously with no `resp_valid`. After release, a new request completes normally and the pointer starts at 0.
6. Counter saturation: with CW forced to 2, run 5 conversions. Required: `conv_count` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/temp_rom_pkg.sv
// rtl/temp_rom_pkg.sv - shared types and constants for the temperature ROM arbiter
package temp_rom_pkg;

    localparam int ROM_AW = 9;
    localparam int ROM_DW = 8;

    localparam logic UNIT_C2F = 1'b0;
    localparam logic UNIT_F2C = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/temp_rom_arbiter_rr_arb2.sv
// rtl/temp_rom_arbiter_rr_arb2.sv - two-way round-robin grant logic
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // A lone request wins outright; on contention the pointer picks the winner
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/temp_rom_arbiter.sv
// rtl/temp_rom_arbiter.sv - two-port sequencer in front of the temperature ROM
module temp_rom_arbiter
    import temp_rom_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_unit,
    input  logic [2*DW-1:0] req_value,
    output logic [1:0]      req_ready,
    output logic [1:0]      resp_valid,
    output logic [DW-1:0]   resp_data,
    input  logic [1:0]      resp_ready,
    output logic [AW-1:0]   rom_addr,
    input  logic [DW-1:0]   rom_data,
    output logic            busy,
    output logic [CW-1:0]   conv_count
);

    state_t        state;
    logic          ptr;
    logic          gidx;
    logic [1:0]    gnt;
    logic          sel;
    logic          sel_unit;
    logic [DW-1:0] sel_value;
    logic          resp_fire;

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign sel       = gnt[1];
    assign sel_unit  = sel ? req_unit[1] : req_unit[0];
    assign sel_value = sel ? req_value[2*DW-1:DW] : req_value[DW-1:0];
    assign resp_fire = (state == RESP) && resp_ready[gidx];

    assign req_ready  = (state == IDLE) ? gnt : 2'b00;
    assign resp_valid = (state == RESP) ? (gidx ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (state != IDLE);

    // Sequence one request at a time through the ROM's registered read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (|req_valid) state <= ISSUE;
                ISSUE:   state <= WAIT;
                WAIT:    state <= RESP;
                RESP:    if (resp_fire) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Latch address and owner on accept, capture ROM data one cycle after issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            gidx      <= 1'b0;
            resp_data <= '0;
        end else begin
            if (state == IDLE && |req_valid) begin
                rom_addr <= AW'({sel_unit, sel_value});
                gidx     <= sel;
            end
            if (state == WAIT) begin
                resp_data <= rom_data;
            end
        end
    end

    // Pointer moves only on completion so a withdrawn request never skews fairness
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= 1'b0;
            conv_count <= '0;
        end else if (resp_fire) begin
            ptr <= ~gidx;
            if (conv_count != {CW{1'b1}}) begin
                conv_count <= conv_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_temp_rom_arbiter.sv
// tb/tb_temp_rom_arbiter.sv - directed scoreboard bench for temp_rom_arbiter
module tb_temp_rom_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_unit;
    logic [15:0] req_value;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_ready;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        busy;
    logic [15:0] conv_count;

    logic [1:0]  req_ready2;
    logic [1:0]  resp_valid2;
    logic [7:0]  resp_data2;
    logic [8:0]  rom_addr2;
    logic [7:0]  rom_data2;
    logic        busy2;
    logic [1:0]  conv_count2;

    int nchecks = 0;
    int nerr    = 0;
    logic [8:0] sb_q[$];

    temp_rom_arbiter #(.AW(9), .DW(8), .CW(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_unit(req_unit), .req_value(req_value),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(resp_ready), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .conv_count(conv_count)
    );

    temp_rom_arbiter #(.AW(9), .DW(8), .CW(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_unit(req_unit), .req_value(req_value),
        .req_ready(req_ready2), .resp_valid(resp_valid2), .resp_data(resp_data2),
        .resp_ready(resp_ready), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .busy(busy2), .conv_count(conv_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: one-cycle registered read
    always @(posedge clk) begin
        rom_data  <= rom_addr[7:0] ^ {8{rom_addr[8]}};
        rom_data2 <= rom_addr2[7:0] ^ {8{rom_addr2[8]}};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            sb_q.delete();
        end else begin
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'(1));
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    sb_q.push_back({i[0], req_value[i*8 +: 8] ^ {8{req_unit[i]}}});
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (sb_q.size() == 0) begin
                        nchecks++;
                        nerr++;
                        $error("FAIL sb_unexpected observed=resp%0d expected=none", i);
                    end else begin
                        logic [8:0] e;
                        e = sb_q.pop_front();
                        check("sb_owner", 32'(i), 32'(e[8]));
                        check("sb_data", 32'(resp_data), 32'(e[7:0]));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_conv(input int idx, input logic unit, input logic [7:0] val);
        int n;
        step();
        req_valid = 2'b00;
        req_valid[idx] = 1'b1;
        req_unit[idx] = unit;
        req_value[idx*8 +: 8] = val;
        n = 0;
        @(negedge clk);
        while (!req_ready[idx] && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("conv_accept", 32'(req_ready[idx]), 32'(1));
        step();
        req_valid = 2'b00;
        n = 0;
        @(negedge clk);
        while (!resp_valid[idx] && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("conv_resp", 32'(resp_valid[idx]), 32'(1));
        step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = 2'b00;
        req_unit   = 2'b00;
        req_value  = 16'h0000;
        resp_ready = 2'b11;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_addr", 32'(rom_addr), 32'(0));
        check("rst_data", 32'(resp_data), 32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_count", 32'(conv_count), 32'(0));
        step();
        reset_n = 1'b1;

        // 1: single C->F request from requester 0
        step();
        req_valid = 2'b01; req_unit = 2'b00; req_value = {8'd0, 8'd100};
        @(negedge clk); check("t1_ready", 32'(req_ready), 32'(2'b01));
        step(); req_valid = 2'b00;
        @(negedge clk); check("t1_addr", 32'(rom_addr), 32'(100));
        check("t1_busy", 32'(busy), 32'(1));
        check("t1_rv_t1", 32'(resp_valid), 32'(0));
        step();
        @(negedge clk); check("t1_rv_t2", 32'(resp_valid), 32'(0));
        step();
        @(negedge clk); check("t1_rv_t3", 32'(resp_valid), 32'(2'b01));
        check("t1_data", 32'(resp_data), 32'(100));
        step();
        @(negedge clk); check("t1_count", 32'(conv_count), 32'(1));
        check("t1_idle", 32'(busy), 32'(0));

        // 2: single F->C request from requester 1
        step();
        req_valid = 2'b10; req_unit = 2'b10; req_value = {8'h0F, 8'd0};
        @(negedge clk); check("t2_ready", 32'(req_ready), 32'(2'b10));
        step(); req_valid = 2'b00;
        @(negedge clk); check("t2_addr", 32'(rom_addr), 32'(9'h10F));
        check("t2_rv_t1", 32'(resp_valid), 32'(0));
        step();
        @(negedge clk); check("t2_rv_t2", 32'(resp_valid), 32'(0));
        step();
        @(negedge clk); check("t2_rv_t3", 32'(resp_valid), 32'(2'b10));
        check("t2_data", 32'(resp_data), 32'(8'hF0));
        step();
        @(negedge clk); check("t2_count", 32'(conv_count), 32'(2));

        // 3: both requesters held valid, grants alternate
        step();
        req_valid = 2'b11; req_unit = 2'b10; req_value = {8'h44, 8'h33};
        for (int i = 0; i < 16; i++) begin
            logic [1:0] exp_rdy;
            exp_rdy = 2'b00;
            if (i % 4 == 0) exp_rdy = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk); check("t3_grant", 32'(req_ready), 32'(exp_rdy));
            step();
        end
        req_valid = 2'b00;
        @(negedge clk); check("t3_count", 32'(conv_count), 32'(6));

        // 4: response backpressure
        step();
        resp_ready = 2'b00;
        req_valid = 2'b01; req_unit = 2'b01; req_value = {8'h00, 8'h5A};
        @(negedge clk); check("t4_ready", 32'(req_ready), 32'(2'b01));
        step(); req_valid = 2'b00;
        step();
        step();
        req_valid = 2'b10; req_unit = 2'b00; req_value = {8'h22, 8'h00};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_rv", 32'(resp_valid), 32'(2'b01));
            check("t4_data", 32'(resp_data), 32'(8'hA5));
            check("t4_addr", 32'(rom_addr), 32'(9'h15A));
            check("t4_ready_blk", 32'(req_ready), 32'(0));
            check("t4_count", 32'(conv_count), 32'(6));
            step();
        end
        resp_ready = 2'b11;
        @(negedge clk); check("t4_rel_rv", 32'(resp_valid), 32'(2'b01));
        step();
        @(negedge clk); check("t4_next_ready", 32'(req_ready), 32'(2'b10));
        check("t4_rel_count", 32'(conv_count), 32'(7));
        step(); req_valid = 2'b00;
        step();
        step();
        @(negedge clk); check("t4_rv2", 32'(resp_valid), 32'(2'b10));
        check("t4_data2", 32'(resp_data), 32'(8'h22));
        step();
        @(negedge clk); check("t4_count2", 32'(conv_count), 32'(8));

        // 5: reset in WAIT, pointer left at 1 beforehand
        do_conv(0, 1'b0, 8'h01);
        check("t5_pre_count", 32'(conv_count), 32'(9));
        step();
        req_valid = 2'b01; req_unit = 2'b00; req_value = {8'h00, 8'h02};
        @(negedge clk); check("t5_ready", 32'(req_ready), 32'(2'b01));
        step(); req_valid = 2'b00;
        step();
        reset_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_rv", 32'(resp_valid), 32'(0));
        check("t5_addr", 32'(rom_addr), 32'(0));
        check("t5_data", 32'(resp_data), 32'(0));
        check("t5_count", 32'(conv_count), 32'(0));
        check("t5_req_ready", 32'(req_ready), 32'(0));
        step();
        step();
        @(negedge clk); check("t5_rv_hold", 32'(resp_valid), 32'(0));
        step();
        reset_n = 1'b1;
        step();
        req_valid = 2'b11; req_unit = 2'b10; req_value = {8'h20, 8'h10};
        @(negedge clk); check("t5_ptr0", 32'(req_ready), 32'(2'b01));
        step(); req_valid = 2'b00;
        step();
        step();
        @(negedge clk); check("t5_rv_after", 32'(resp_valid), 32'(2'b01));
        check("t5_data_after", 32'(resp_data), 32'(8'h10));
        step();
        @(negedge clk); check("t5_count_after", 32'(conv_count), 32'(1));

        // 6: saturating counter on the CW=2 instance
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_cnt;
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            do_conv(0, 1'b1, 8'(i * 17));
            check("t6_sat_count", 32'(conv_count2), 32'(exp_cnt));
        end
        check("t6_wide_count", 32'(conv_count), 32'(5));

        step();
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
